rom_fetch: RTL and testbench

Instruction-fetch initiator for the single-beat ROM request/response interface, driving the requester side of the boot ROM. It walks a sequential PC from a reset vector and keeps at most one ROM request in flight. Returned words go into a small prefetch FIFO, which the core front end drains with a valid/ready handshake. A redirect flushes the FIFO and restarts fetch at a new target.

---
 rtl/rom_fetch_pkg.sv | 15 +
 rtl/rom_fetch_buffer.sv | 51 +++++
 rtl/rom_fetch.sv | 78 +++++++
 tb/tb_rom_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared types and constants for the boot ROM instruction fetch unit
package rom_fetch_pkg;

    localparam logic [31:0] ROM_WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rom_fetch_buffer.sv
// rom_fetch_buffer: prefetch FIFO of fetched {pc, instr} entries with single-cycle flush
module rom_fetch_buffer
    import rom_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign head  = empty ? '0 : mem[rd_ptr];

    // entry storage; stale contents are harmless because the head is masked while empty
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// rom_fetch: sequential instruction fetch from the boot ROM into a prefetch FIFO, one request in flight
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_redirect,
    input  logic [31:0] fetch_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    input  logic        fetch_ready,
    output logic        rom_valid,
    output logic        rom_instr,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        rom_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic          outstanding;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          resp;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // issue only when the in-flight word is guaranteed a FIFO slot; same-cycle pops are not credited
    assign rom_valid   = reset && !fetch_redirect && (count + CW'(outstanding) < CW'(DEPTH));
    assign rom_instr   = 1'b1;
    assign rom_addr    = word_align(req_pc);
    assign resp        = rom_ready && outstanding && !fetch_redirect;
    assign fetch_valid = !empty && !fetch_redirect;
    assign pop         = fetch_valid && fetch_ready;
    assign push_data   = '{pc: resp_pc, instr: rom_rdata};
    assign fetch_pc    = head.pc;
    assign fetch_instr = head.instr;

    rom_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (resp && !full),
        .push_data (push_data),
        .pop       (pop),
        .flush     (fetch_redirect),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // PC walk and outstanding-request tracking; redirect overrides issue and response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 1'b0;
        end else if (fetch_redirect) begin
            req_pc      <= word_align(fetch_target);
            outstanding <= 1'b0;
        end else if (rom_valid) begin
            resp_pc     <= req_pc;
            req_pc      <= req_pc + ROM_WORD_BYTES;
            outstanding <= 1'b1;
        end else if (resp) begin
            outstanding <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: table-driven, directed and randomized checks of rom_fetch against a queue-based model
module tb_rom_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_redirect = 1'b0;
    logic [31:0] fetch_target = '0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        rom_valid;
    logic        rom_instr;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        rom_ready;

    logic        resp_q = 1'b0;
    logic [31:0] data_q = '0;
    logic        stray = 1'b0;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic        red;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [14];

    logic [31:0] q [$];
    bit          infl;
    logic [31:0] infl_pc;
    logic [31:0] next_pc;

    rom_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_redirect (fetch_redirect),
        .fetch_target   (fetch_target),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_ready    (fetch_ready),
        .rom_valid      (rom_valid),
        .rom_instr      (rom_instr),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .rom_ready      (rom_ready)
    );

    always #5 clock = ~clock;

    // ROM responder: answers every request the following cycle with addr ^ KEY
    always @(posedge clock) begin
        resp_q <= rom_valid;
        data_q <= rom_addr ^ KEY;
    end

    assign rom_ready = resp_q | stray;
    assign rom_rdata = stray ? 32'hDEADBEEF : data_q;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_redirect = 1'b0;
        fetch_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        q.delete();
        infl = 1'b0;
        next_pc = 32'h0;
    endtask

    // one cycle checked against the model: the FIFO is a queue of pcs, instr is derived from pc
    task automatic mcycle(input logic red, input logic [31:0] tgt, input logic rdy);
        logic erv;
        logic efv;
        fetch_redirect = red;
        fetch_target = tgt;
        fetch_ready = rdy;
        erv = !red && (q.size() + int'(infl) < DEPTH);
        efv = q.size() != 0 && !red;
        @(negedge clock);
        chk("m rom_valid", rom_valid, erv);
        chk("m rom_addr", rom_addr, next_pc);
        chk("m fetch_valid", fetch_valid, efv);
        if (efv) begin
            chk("m fetch_pc", fetch_pc, q[0]);
            chk("m fetch_instr", fetch_instr, q[0] ^ KEY);
        end
        if (red) begin
            q.delete();
            infl = 1'b0;
            next_pc = tgt & ~32'h3;
        end else begin
            if (efv && rdy) void'(q.pop_front());
            if (infl) q.push_back(infl_pc);
            infl = erv;
            if (erv) begin
                infl_pc = next_pc;
                next_pc = next_pc + 32'd4;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
        tbl[9]  = '{1'b1, 32'h43, 1'b1, 1'b0, 32'h18, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b1, 32'h40};
        tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4C, 1'b1, 32'h44};

        // reset values while held in reset
        #2;
        chk("rst rom_valid", rom_valid, 1'b0);
        chk("rst rom_addr", rom_addr, 32'h0);
        chk("rst fetch_valid", fetch_valid, 1'b0);
        chk("rst fetch_pc", fetch_pc, 32'h0);
        chk("rst fetch_instr", fetch_instr, 32'h0);
        chk("rom_instr", rom_instr, 1'b1);

        // stall to full, drain, then redirect with a response in flight and two entries queued
        do_reset();
        for (int i = 0; i < 14; i++) begin
            fetch_redirect = tbl[i].red;
            fetch_target = tbl[i].tgt;
            fetch_ready = tbl[i].rdy;
            @(negedge clock);
            chk($sformatf("t%0d rom_valid", i), rom_valid, tbl[i].rv);
            chk($sformatf("t%0d rom_addr", i), rom_addr, tbl[i].addr);
            chk($sformatf("t%0d fetch_valid", i), fetch_valid, tbl[i].fv);
            if (tbl[i].fv) begin
                chk($sformatf("t%0d fetch_pc", i), fetch_pc, tbl[i].pc);
                chk($sformatf("t%0d fetch_instr", i), fetch_instr, tbl[i].pc ^ KEY);
            end
            @(posedge clock);
            #1;
        end

        // full-rate streaming from reset
        do_reset();
        fetch_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("s%0d rom_valid", i), rom_valid, 1'b1);
            chk($sformatf("s%0d rom_addr", i), rom_addr, 32'(i * 4));
            chk($sformatf("s%0d fetch_valid", i), fetch_valid, i >= 2);
            if (i >= 2) begin
                chk($sformatf("s%0d fetch_pc", i), fetch_pc, 32'((i - 2) * 4));
                chk($sformatf("s%0d fetch_instr", i), fetch_instr, 32'((i - 2) * 4) ^ KEY);
            end
            @(posedge clock);
            #1;
        end

        // asynchronous reset mid-stream with a response pending, then a stray response after release
        #1 reset = 1'b0;
        #1;
        chk("arst rom_valid", rom_valid, 1'b0);
        chk("arst rom_addr", rom_addr, 32'h0);
        chk("arst fetch_valid", fetch_valid, 1'b0);
        chk("arst fetch_pc", fetch_pc, 32'h0);
        chk("arst fetch_instr", fetch_instr, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        stray = 1'b1;
        @(negedge clock);
        chk("arst c0 rom_addr", rom_addr, 32'h0);
        chk("arst c0 fetch_valid", fetch_valid, 1'b0);
        @(posedge clock);
        #1 stray = 1'b0;
        @(negedge clock);
        chk("arst c1 fetch_valid", fetch_valid, 1'b0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("arst c2 fetch_valid", fetch_valid, 1'b1);
        chk("arst c2 fetch_pc", fetch_pc, 32'h0);
        chk("arst c2 fetch_instr", fetch_instr, KEY);
        @(posedge clock);
        #1;

        // model-checked phase: PC wrap at the top of the address space, then random traffic
        do_reset();
        mcycle(1'b1, 32'hFFFFFFFE, 1'b1);
        mcycle(1'b0, 32'h0, 1'b1);
        chk("wrap rom_addr", rom_addr, 32'h0);
        for (int i = 0; i < 6; i++) mcycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            logic        red;
            logic [31:0] tgt;
            logic        rdy;
            red = $urandom_range(0, 24) == 0;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) begin
                mcycle(1'b1, $urandom, rdy);
                red = 1'b1;
            end
            mcycle(red, tgt, rdy);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
